// File: rtl/ber_pkg.sv
// Shared types, default widths and helpers for the PRBS bit-error-rate checker.
package ber_pkg;

  typedef enum logic [1:0] {StIdle, StSearch, StMeasure} ber_state_t;

  // Widths for the default MAX_DELAY = WINDOW = 511 build
  localparam int unsigned DLY_W = $clog2(511);
  localparam int unsigned WIN_W = $clog2(511 + 1);

  // Adds a single bit, sticking at max once it is reached
  function automatic logic [63:0] sat_add(input logic [63:0] val, input logic inc,
                                          input logic [63:0] max);
    return (inc && (val != max)) ? val + 64'd1 : val;
  endfunction

endpackage

// File: rtl/ber_delay_line.sv
// Reference delay line: Depth shift stages on each valid plus a tap mux,
// where tap 0 is the live input bit.
module ber_delay_line #(
  parameter int unsigned Depth = 510,
  parameter int unsigned SelW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            valid_i,
  input  logic            bit_i,
  input  logic [SelW-1:0] sel_i,
  output logic            tap_o
);

  logic [Depth-1:0] sr_q;
  logic [Depth:0]   taps;

  // No reset: every tap is refilled before a search window can read it
  always_ff @(posedge clk_i) begin
    if (valid_i) begin
      sr_q[0] <= bit_i;
      for (int i = 1; i < int'(Depth); i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  always_comb begin
    taps  = {sr_q, bit_i};
    tap_o = taps[sel_i];
  end

endmodule

// File: rtl/ber_checker.sv
// PRBS bit-error-rate checker: searches all channel delays for the fewest
// errors, locks to the best one and counts bits/errors. Optional relock on a
// bad measurement window is enabled by defining BER_RELOCK_EN.
module ber_checker
  import ber_pkg::*;
#(
  parameter int unsigned PRBS_LEN  = 511,
  parameter int unsigned MAX_DELAY = 511,
  parameter int unsigned WINDOW    = 511,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned RELOCK_TH = 128
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_enable,
  input  logic                           i_valid,
  input  logic                           i_ref_bit,
  input  logic                           i_rx_bit,
  input  logic [1:0]                     i_phase,
  output logic                           o_locked,
  output logic                           o_busy,
  output logic [$clog2(MAX_DELAY)-1:0]   o_delay,
  output logic [$clog2(WINDOW+1)-1:0]    o_min_err,
  output logic [CNT_W-1:0]               o_bit_count,
  output logic [CNT_W-1:0]               o_err_count
);

  localparam int unsigned DelayW = $clog2(MAX_DELAY);
  localparam int unsigned WindowW = $clog2(WINDOW + 1);
  localparam logic [DelayW-1:0]  LastDelay = DelayW'(MAX_DELAY - 1);
  localparam logic [WindowW-1:0] LastWin   = WindowW'(WINDOW - 1);
  localparam logic [CNT_W-1:0]   CntMax    = '1;

  if (MAX_DELAY < 2 || WINDOW < MAX_DELAY - 1 || PRBS_LEN < 2 || RELOCK_TH > WINDOW)
  begin : g_bad_cfg
    $error("ber_checker: unsupported parameter combination");
  end

  ber_state_t         state_q, state_d;
  logic               en_q;
  logic [1:0]         phase_q;
  logic [DelayW-1:0]  cur_delay_q, cur_delay_d;
  logic [DelayW-1:0]  best_q, best_d;
  logic [WindowW-1:0] min_err_q, min_err_d;
  logic [WindowW-1:0] win_cnt_q, win_cnt_d;
  logic [WindowW-1:0] win_err_q, win_err_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               tap;
  logic               err;
  logic               start;
  logic               win_done;
  logic [WindowW-1:0] total;

  ber_delay_line #(
    .Depth(MAX_DELAY - 1),
    .SelW (DelayW)
  ) u_delay_line (
    .clk_i  (clk),
    .valid_i(i_valid),
    .bit_i  (i_ref_bit),
    .sel_i  (cur_delay_q),
    .tap_o  (tap)
  );

  always_comb begin
    state_d     = state_q;
    cur_delay_d = cur_delay_q;
    best_d      = best_q;
    min_err_d   = min_err_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;

    err      = i_rx_bit ^ tap;
    total    = win_err_q + WindowW'(err);
    win_done = (win_cnt_q == LastWin);
    // Rising enable or a phase change while enabled both restart the search
    start    = i_enable && (!en_q || (i_phase != phase_q));

    if (!i_enable) begin
      state_d = StIdle;
    end else if (start) begin
      state_d     = StSearch;
      cur_delay_d = '0;
      best_d      = '0;
      min_err_d   = '1;
      win_cnt_d   = '0;
      win_err_d   = '0;
      bit_cnt_d   = '0;
      err_cnt_d   = '0;
    end else if (i_valid) begin
      unique case (state_q)
        StSearch: begin
          if (win_done) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (total < min_err_q) begin
              min_err_d = total;
              best_d    = cur_delay_q;
            end
            if (cur_delay_q == LastDelay) begin
              cur_delay_d = best_d;
              state_d     = StMeasure;
            end else begin
              cur_delay_d = cur_delay_q + 1'b1;
            end
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = total;
          end
        end
        StMeasure: begin
          bit_cnt_d = CNT_W'(sat_add(64'(bit_cnt_q), 1'b1, 64'(CntMax)));
          err_cnt_d = CNT_W'(sat_add(64'(err_cnt_q), err, 64'(CntMax)));
`ifdef BER_RELOCK_EN
          if (win_done) begin
            win_cnt_d = '0;
            win_err_d = '0;
            // Relock keeps the measurement counters for readout
            if (total >= WindowW'(RELOCK_TH)) begin
              state_d     = StSearch;
              cur_delay_d = '0;
              best_d      = '0;
              min_err_d   = '1;
            end
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = total;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      en_q        <= 1'b0;
      phase_q     <= i_phase;
      cur_delay_q <= '0;
      best_q      <= '0;
      min_err_q   <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= i_enable;
      phase_q     <= i_phase;
      cur_delay_q <= cur_delay_d;
      best_q      <= best_d;
      min_err_q   <= min_err_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_comb begin
    o_locked    = (state_q == StMeasure);
    o_busy      = (state_q == StSearch);
    o_delay     = best_q;
    o_min_err   = min_err_q;
    o_bit_count = bit_cnt_q;
    o_err_count = err_cnt_q;
  end

endmodule

// File: tb/tb_ber_checker.sv
// Self-checking bench for ber_checker with a small configuration and a
// behavioural model that scores every candidate delay from recorded samples.
module tb_ber_checker;

  localparam int MD   = 16;
  localparam int W    = 31;
  localparam int CW   = 10;
  localparam int DW   = 4;
  localparam int EW   = 5;
  localparam int CMAX = (1 << CW) - 1;
  localparam int MALL = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_enable = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ref_bit = 1'b0;
  logic          i_rx_bit = 1'b0;
  logic [1:0]    i_phase = 2'd0;
  logic          o_locked, o_busy;
  logic [DW-1:0] o_delay;
  logic [EW-1:0] o_min_err;
  logic [CW-1:0] o_bit_count, o_err_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] lfsr;
  bit   ref_all[$];
  bit   sref[$];
  bit   srx[$];
  bit   rec = 1'b1;
  int   chan_d = 0;
  int   rx_cnt = 0;
  int   cur_den = 1;
  int   cur_errper = 0;
  int   last_bd = 0;

  ber_checker #(
    .PRBS_LEN (511),
    .MAX_DELAY(MD),
    .WINDOW   (W),
    .CNT_W    (CW),
    .RELOCK_TH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_enable   (i_enable),
    .i_valid    (i_valid),
    .i_ref_bit  (i_ref_bit),
    .i_rx_bit   (i_rx_bit),
    .i_phase    (i_phase),
    .o_locked   (o_locked),
    .o_busy     (o_busy),
    .o_delay    (o_delay),
    .o_min_err  (o_min_err),
    .o_bit_count(o_bit_count),
    .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  // Channel: rx is the reference delayed chan_d valids, optionally inverted
  task automatic tick(input bit v, input bit flip);
    bit r;
    bit x;
    int idx;
    @(negedge clk);
    r = lfsr[8] ^ lfsr[4];
    if (v) begin
      lfsr = {lfsr[7:0], r};
      ref_all.push_back(r);
      idx = ref_all.size() - 1 - chan_d;
      x = ((idx >= 0) ? ref_all[idx] : 1'b0) ^ flip;
      if (rec) begin
        sref.push_back(r);
        srx.push_back(x);
      end
    end else begin
      r = 1'($urandom);
      x = 1'($urandom);
    end
    i_valid   = v;
    i_ref_bit = r;
    i_rx_bit  = x;
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic run_valids(input int target, input int den, input int errper);
    int budget;
    bit v;
    bit fl;
    budget = (target - sref.size()) * den * 8 + 50;
    while (sref.size() < target && budget > 0) begin
      v  = ($urandom_range(0, den - 1) == 0);
      fl = 1'b0;
      if (v) begin
        if (errper != 0 && (rx_cnt % errper) == errper - 1) fl = 1'b1;
        rx_cnt++;
      end
      tick(v, fl);
      budget--;
    end
    if (sref.size() < target) begin
      n_tests++; n_fail++;
      $display("FAIL run_valids timeout: got %0d valids, required %0d", sref.size(), target);
    end
  endtask

  task automatic begin_run();
    @(negedge clk);
    i_valid  = 1'b0;
    i_enable = 1'b0;
    @(negedge clk);
    i_enable = 1'b1;
    @(negedge clk);
    sref.delete();
    srx.delete();
    rec = 1'b1;
  endtask

  // Score each delay over its own window of the recorded stream; strict < keeps earliest
  task automatic model_lock(output int bd, output int me);
    int e;
    int n;
    me = MALL;
    bd = 0;
    for (int d = 0; d < MD; d++) begin
      e = 0;
      for (int k = 0; k < W; k++) begin
        n = d * W + k;
        e += int'(srx[n] ^ sref[n - d]);
      end
      if (e < me) begin
        me = e;
        bd = d;
      end
    end
  endtask

  task automatic model_meas(input int bd, output int bits, output int errs);
    bits = 0;
    errs = 0;
    for (int n = MD * W; n < sref.size(); n++) begin
      bits++;
      errs += int'(srx[n] ^ sref[n - bd]);
    end
    if (bits > CMAX) bits = CMAX;
    if (errs > CMAX) errs = CMAX;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %0b want 0", o_locked); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", o_busy); end
    n_tests++; if (o_delay !== '0) begin n_fail++; $display("FAIL reset_delay: got %0d want 0", o_delay); end
    n_tests++; if (o_min_err !== '0) begin n_fail++; $display("FAIL reset_min_err: got %0d want 0", o_min_err); end
    n_tests++; if (o_bit_count !== '0 || o_err_count !== '0) begin
      n_fail++; $display("FAIL reset_counts: got %0d/%0d want 0/0", o_bit_count, o_err_count);
    end
    // Enable held high through reset counts as a rising edge afterwards
    rst = 1'b1;
    i_enable = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL reset_enable_start: busy %0b want 1", o_busy); end
    i_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lock(input string tag, input int den, input int errper, input int nmeas);
    int bd, me, bits, errs;
    cur_den = den;
    cur_errper = errper;
    chan_d = $urandom_range(0, MD - 1);
    begin_run();
    run_valids(MD * W - 1, den, errper);
    idle();
    n_tests++; if (o_busy !== 1'b1 || o_locked !== 1'b0) begin
      n_fail++; $display("FAIL %s_prelock: busy/locked %0b/%0b want 1/0", tag, o_busy, o_locked);
    end
    run_valids(MD * W, den, errper);
    idle();
    model_lock(bd, me);
    last_bd = bd;
    n_tests++; if (o_locked !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_lock: locked/busy %0b/%0b want 1/0", tag, o_locked, o_busy);
    end
    n_tests++; if (o_delay !== DW'(bd)) begin
      n_fail++; $display("FAIL %s_delay: got %0d want %0d (chan %0d)", tag, o_delay, bd, chan_d);
    end
    n_tests++; if (o_min_err !== EW'(me)) begin
      n_fail++; $display("FAIL %s_min_err: got %0d want %0d", tag, o_min_err, me);
    end
    run_valids(MD * W + nmeas, den, errper);
    idle();
    model_meas(bd, bits, errs);
    n_tests++; if (o_bit_count !== CW'(bits)) begin
      n_fail++; $display("FAIL %s_bit_count: got %0d want %0d", tag, o_bit_count, bits);
    end
    n_tests++; if (o_err_count !== CW'(errs)) begin
      n_fail++; $display("FAIL %s_err_count: got %0d want %0d", tag, o_err_count, errs);
    end
  endtask

  task automatic test_phase_restart();
    int bd, me, prev;
    prev = last_bd;
    rec = 1'b0;
    i_phase = i_phase + 2'd2;
    tick(1'b1, 1'b0);
    sref.delete();
    srx.delete();
    rec = 1'b1;
    idle();
    n_tests++; if (o_locked !== 1'b0 || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL phase_state: locked/busy %0b/%0b want 0/1", o_locked, o_busy);
    end
    n_tests++; if (o_bit_count !== '0 || o_err_count !== '0 || o_min_err !== EW'(MALL)) begin
      n_fail++; $display("FAIL phase_clear: bits/errs/min %0d/%0d/%0d want 0/0/%0d",
                         o_bit_count, o_err_count, o_min_err, MALL);
    end
    run_valids(MD * W, cur_den, cur_errper);
    idle();
    model_lock(bd, me);
    n_tests++; if (o_locked !== 1'b1 || o_delay !== DW'(bd) || o_delay !== DW'(prev)) begin
      n_fail++; $display("FAIL phase_relock: locked %0b delay %0d want 1/%0d (before %0d)",
                         o_locked, o_delay, bd, prev);
    end
  endtask

  task automatic test_saturate();
    int bits, errs;
    logic [CW-1:0] held;
    test_lock("sat_pre", 1, 0, 5);
    run_valids(MD * W + 1100, 1, 1);
    idle();
    model_meas(last_bd, bits, errs);
    n_tests++; if (o_bit_count !== CW'(bits) || o_err_count !== CW'(errs)) begin
      n_fail++; $display("FAIL saturate: bits/errs %0d/%0d want %0d/%0d",
                         o_bit_count, o_err_count, bits, errs);
    end
    held = o_bit_count;
    // Disable mid-measurement: state idles, readout holds
    i_enable = 1'b0;
    rec = 1'b0;
    repeat (20) tick(1'b1, 1'b1);
    idle();
    n_tests++; if (o_locked !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL disable_state: locked/busy %0b/%0b want 0/0", o_locked, o_busy);
    end
    n_tests++; if (o_bit_count !== held || o_delay !== DW'(last_bd)) begin
      n_fail++; $display("FAIL disable_hold: bits %0d delay %0d want %0d/%0d",
                         o_bit_count, o_delay, held, last_bd);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    i_enable = 1'b1;
    @(negedge clk);
    n_tests++; if (o_busy !== 1'b1 || o_locked !== 1'b0) begin
      n_fail++; $display("FAIL reenable_state: busy/locked %0b/%0b want 1/0", o_busy, o_locked);
    end
    n_tests++; if (o_bit_count !== '0 || o_err_count !== '0) begin
      n_fail++; $display("FAIL reenable_counts: got %0d/%0d want 0/0", o_bit_count, o_err_count);
    end
    n_tests++; if (o_delay !== '0 || o_min_err !== EW'(MALL)) begin
      n_fail++; $display("FAIL reenable_init: delay/min %0d/%0d want 0/%0d", o_delay, o_min_err, MALL);
    end
  endtask

  initial begin
    lfsr = 9'($urandom_range(1, 511));
    test_reset();
    test_lock("clean", 1, 0, 200);
    test_lock("errors", 1, 7, 300);
    test_lock("sparse", 3, 0, 150);
    test_phase_restart();
    test_saturate();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
